// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between fetch and data paths, data first,
// with a starvation guard for fetch and a per-grant timeout.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err,
  output logic        tmo
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SL = SW'(STARVE_LIMIT);
  typedef enum logic [1:0] {IDLE, SERVE_D, SERVE_I} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] dstreak_q, dstreak_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic err_q, err_d, tmo_q, tmo_d;
  logic dreq, live, fin, expire, sd, si;
  always_comb begin
    sd = state_q == SERVE_D;
    si = state_q == SERVE_I;
    dreq = dREN | dWEN;
    live = sd ? dreq : si & iREN;
    // ACCESS and ERROR both end the transfer; bit 0 then tells them apart
    fin = live & ramstate[1];
    expire = live & ~fin & (tcnt_q == 8'(TIMEOUT - 1));
    ramREN = sd ? dREN & ~dWEN : si & iREN;
    ramWEN = sd & dWEN;
    ramaddr = sd ? daddr : si ? iaddr : '0;
    ramstore = sd ? dstore : '0;
    iwait = iREN & ~(si & fin);
    dwait = dreq & ~(sd & fin);
    iload = si & fin ? ramload : '0;
    dload = sd & fin ? ramload : '0;
    err = err_q;
    tmo = tmo_q;
    state_d = state_q;
    dstreak_d = dstreak_q;
    tcnt_d = tcnt_q;
    err_d = err_q | (fin & ramstate[0]);
    tmo_d = tmo_q | expire;
    if (state_q == IDLE) begin
      tcnt_d = '0;
      if (dreq & ~(iREN & dstreak_q == SL)) begin
        state_d = SERVE_D;
        dstreak_d = ~iREN ? '0 : dstreak_q == SL ? SL : dstreak_q + SW'(1);
      end else if (iREN) begin
        state_d = SERVE_I;
        dstreak_d = '0;
      end
    end else if (~live | fin | expire) begin
      state_d = IDLE;
    end else begin
      tcnt_d = tcnt_q + 8'd1;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      dstreak_q <= '0;
      tcnt_q <= '0;
      err_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dstreak_q <= dstreak_d;
      tcnt_q <= tcnt_d;
      err_q <= err_d;
      tmo_q <= tmo_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random requesters and RAM against a transaction-level
// model; expected outputs are queued per cycle and checked by a monitor.
module tb_mem_arbiter;
  localparam int SL = 4;
  localparam int TO = 64;
  logic CLK = 1'b0;
  logic RST, iREN, dREN, dWEN, iwait, dwait, ramREN, ramWEN, err, tmo;
  logic [31:0] iaddr, iload, daddr, dstore, dload, ramaddr, ramstore, ramload;
  logic [1:0] ramstate;
  always #5 CLK = ~CLK;
  mem_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err), .tmo(tmo)
  );
  typedef struct packed {
    logic iwait;
    logic [31:0] iload;
    logic dwait;
    logic [31:0] dload;
    logic ren;
    logic wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic err;
    logic tmo;
    logic [31:0] cyc;
  } exp_t;
  exp_t sbq[$];
  int checks = 0;
  int fails = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input logic [31:0] cyc);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask
  initial forever begin
    exp_t e;
    @(negedge CLK);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("iwait", 32'(iwait), 32'(e.iwait), e.cyc);
      chk("iload", iload, e.iload, e.cyc);
      chk("dwait", 32'(dwait), 32'(e.dwait), e.cyc);
      chk("dload", dload, e.dload, e.cyc);
      chk("ramREN", 32'(ramREN), 32'(e.ren), e.cyc);
      chk("ramWEN", 32'(ramWEN), 32'(e.wen), e.cyc);
      chk("ramaddr", ramaddr, e.addr, e.cyc);
      chk("ramstore", ramstore, e.store, e.cyc);
      chk("err", 32'(err), 32'(e.err), e.cyc);
      chk("tmo", 32'(tmo), 32'(e.tmo), e.cyc);
    end
  end
  // reference model: who owns the RAM, how long, and the data-grant streak
  int owner, age, streak;
  bit err_s, tmo_s, i_hold, d_hold, dr, dw;
  initial begin
    exp_t e;
    int pi, pd, pw, r, phase;
    bit rst_now, dreq, live, fin, stuck;
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
    ramload = 0; ramstate = 2'd1;
    owner = 0; age = 0; streak = 0; err_s = 0; tmo_s = 0; i_hold = 0; d_hold = 0;
    repeat (2) @(posedge CLK);
    #1;
    for (int c = 0; c < 4000; c++) begin
      phase = c / 1000;
      pi = phase == 1 ? 100 : 40;
      pd = phase == 1 ? 100 : 50;
      pw = phase == 2 ? 300 : 60;
      stuck = phase == 2 && (c % 1000) < 700;
      rst_now = (c % 997 == 600) || $urandom_range(0, 599) == 0;
      if (!i_hold && $urandom_range(0, 99) < pi) begin
        i_hold = 1;
        iaddr = $urandom;
      end
      if (!d_hold && $urandom_range(0, 99) < pd) begin
        d_hold = 1;
        {dr, dw} = 2'($urandom_range(1, 3));
        daddr = $urandom;
        dstore = $urandom;
      end
      if (i_hold && $urandom_range(0, pw - 1) == 0) i_hold = 0;
      if (d_hold && $urandom_range(0, pw - 1) == 0) d_hold = 0;
      iREN = i_hold;
      dREN = d_hold & dr;
      dWEN = d_hold & dw;
      r = $urandom_range(0, 99);
      ramstate = stuck ? 2'd1 : r < 10 ? 2'd0 : r < 55 ? 2'd1 : r < (phase == 3 ? 85 : 95) ? 2'd2 : 2'd3;
      ramload = $urandom;
      RST = rst_now;
      dreq = dREN | dWEN;
      live = owner == 1 ? dreq : owner == 2 ? iREN : 1'b0;
      fin = live && ramstate >= 2'd2;
      e.iwait = iREN && !(owner == 2 && fin);
      e.dwait = dreq && !(owner == 1 && fin);
      e.iload = (owner == 2 && fin) ? ramload : 32'd0;
      e.dload = (owner == 1 && fin) ? ramload : 32'd0;
      e.ren = owner == 1 ? (dREN && !dWEN) : owner == 2 ? iREN : 1'b0;
      e.wen = owner == 1 && dWEN;
      e.addr = owner == 1 ? daddr : owner == 2 ? iaddr : 32'd0;
      e.store = owner == 1 ? dstore : 32'd0;
      e.err = err_s;
      e.tmo = tmo_s;
      e.cyc = 32'(c);
      sbq.push_back(e);
      if (fin && owner == 2) i_hold = 0;
      if (fin && owner == 1) d_hold = 0;
      if (rst_now) begin
        owner = 0; age = 0; streak = 0; err_s = 0; tmo_s = 0;
      end else if (owner == 0) begin
        age = 0;
        if (dreq && !(iREN && streak == SL)) begin
          owner = 1;
          streak = iREN ? (streak < SL ? streak + 1 : SL) : 0;
        end else if (iREN) begin
          owner = 2;
          streak = 0;
        end
      end else if (!live) begin
        owner = 0;
      end else if (fin) begin
        if (ramstate == 2'd3) err_s = 1;
        owner = 0;
      end else if (age == TO - 1) begin
        tmo_s = 1;
        owner = 0;
      end else begin
        age++;
      end
      @(posedge CLK);
      #1;
    end
    @(negedge CLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
